// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, refill state encoding and address field helpers
// for the cache refill controller.
//   ADDR_W/IDX_W/OFF_W/TAG_W/CNT_W - default address, index, offset, tag and
//                                    miss counter widths
//   refill_state_t                 - refill controller states
//   tag_of/idx_of/line_addr_of     - field extraction for the default widths
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 3;
  localparam int CNT_W  = 16;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_D,
    ST_REQ_I,
    ST_FILL_D,
    ST_FILL_I
  } refill_state_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:IDX_W+OFF_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W+OFF_W-1:OFF_W];
  endfunction

  // Clearing the offset by mask keeps every address bit in use.
  function automatic logic [ADDR_W-1:0] line_addr_of(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off_mask;
    off_mask = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    return addr & ~off_mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk   - system clock
//   reset - asynchronous active-high reset, clears count
//   inc   - count one event this cycle
//   count - current event count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler between the I/D caches and main memory.
// Picks one miss (data side first), fetches the 64-bit line over a req/ack
// port and then pulses a one-cycle fill into the cache that missed.
//   clk, reset               - clock, asynchronous active-high reset
//   i_addr, i_miss           - instruction fetch address and tag miss
//   d_addr, d_en, d_miss     - data access address, valid and tag miss
//   mem_req, mem_addr        - line request held until mem_ack
//   mem_ack, mem_rdata       - one-cycle response with the line data
//   fill_data/idx/tag        - registered fill payload
//   i_fill, d_fill           - one-cycle fill strobes per side
//   i_stall, d_stall         - combinational pipeline freezes
//   i_miss_cnt, d_miss_cnt   - saturating miss counters
module cache_refill_ctrl #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int IDX_W  = cache_pkg::IDX_W,
  parameter int OFF_W  = cache_pkg::OFF_W,
  parameter int CNT_W  = cache_pkg::CNT_W,
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_en,
  input  logic              d_miss,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic [63:0]       fill_data,
  output logic              i_fill,
  output logic              d_fill,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [TAG_W-1:0]  fill_tag,
  output logic              i_stall,
  output logic              d_stall,
  output logic [CNT_W-1:0]  i_miss_cnt,
  output logic [CNT_W-1:0]  d_miss_cnt
);

  import cache_pkg::*;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  refill_state_t     state_reg, state_next;
  logic              d_take;
  logic              i_take;
  logic [ADDR_W-1:0] sel_addr;

  // A data miss only counts while the access is valid; it beats an icache miss.
  assign d_take   = d_en && d_miss;
  assign i_take   = i_miss && !d_take;
  assign sel_addr = d_take ? d_addr : i_addr;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (d_take)      state_next = ST_REQ_D;
        else if (i_miss) state_next = ST_REQ_I;
      end
      ST_REQ_D:  if (mem_ack) state_next = ST_FILL_D;
      ST_REQ_I:  if (mem_ack) state_next = ST_FILL_I;
      ST_FILL_D: state_next = ST_IDLE;
      ST_FILL_I: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      fill_data <= '0;
      i_fill    <= 1'b0;
      d_fill    <= 1'b0;
      fill_idx  <= '0;
      fill_tag  <= '0;
    end else begin
      state_reg <= state_next;
      mem_req   <= (state_next == ST_REQ_D) || (state_next == ST_REQ_I);
      i_fill    <= (state_next == ST_FILL_I);
      d_fill    <= (state_next == ST_FILL_D);
      // Address is captured only when leaving IDLE; later input changes are ignored.
      if ((state_reg == ST_IDLE) && (state_next != ST_IDLE)) begin
        mem_addr <= sel_addr & ~OFF_MASK;
        fill_idx <= sel_addr[IDX_W+OFF_W-1:OFF_W];
        fill_tag <= sel_addr[ADDR_W-1:IDX_W+OFF_W];
      end
      if (((state_reg == ST_REQ_D) || (state_reg == ST_REQ_I)) && mem_ack) begin
        fill_data <= mem_rdata;
      end
    end
  end

  assign i_stall = i_miss || (state_reg == ST_REQ_I) || (state_reg == ST_FILL_I);
  assign d_stall = d_take || (state_reg == ST_REQ_D) || (state_reg == ST_FILL_D);

  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state_reg == ST_IDLE) && i_take),
    .count (i_miss_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state_reg == ST_IDLE) && d_take),
    .count (d_miss_cnt)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Testbench for cache_refill_ctrl. Two instances share all inputs: the default
// one (16-bit counters) and one with 4-bit counters for saturation.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr, d_addr;
  logic        i_miss, d_en, d_miss;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        mem_req, i_fill, d_fill, i_stall, d_stall;
  logic [31:0] mem_addr;
  logic [63:0] fill_data;
  logic [4:0]  fill_idx;
  logic [23:0] fill_tag;
  logic [15:0] i_miss_cnt, d_miss_cnt;

  logic        mem_req_s, i_fill_s, d_fill_s, i_stall_s, d_stall_s;
  logic [31:0] mem_addr_s;
  logic [63:0] fill_data_s;
  logic [4:0]  fill_idx_s;
  logic [23:0] fill_tag_s;
  logic [3:0]  i_miss_cnt_s, d_miss_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;
  int i_n     = 0;  // model: icache misses accepted since reset
  int d_n     = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .reset(reset), .i_addr(i_addr), .i_miss(i_miss),
    .d_addr(d_addr), .d_en(d_en), .d_miss(d_miss),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_data(fill_data), .i_fill(i_fill), .d_fill(d_fill),
    .fill_idx(fill_idx), .fill_tag(fill_tag), .i_stall(i_stall), .d_stall(d_stall),
    .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
  );

  cache_refill_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .i_addr(i_addr), .i_miss(i_miss),
    .d_addr(d_addr), .d_en(d_en), .d_miss(d_miss),
    .mem_req(mem_req_s), .mem_addr(mem_addr_s), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_data(fill_data_s), .i_fill(i_fill_s), .d_fill(d_fill_s),
    .fill_idx(fill_idx_s), .fill_tag(fill_tag_s), .i_stall(i_stall_s), .d_stall(d_stall_s),
    .i_miss_cnt(i_miss_cnt_s), .d_miss_cnt(d_miss_cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic check_counters();
    check("i_miss_cnt", i_miss_cnt, i_n);
    check("d_miss_cnt", d_miss_cnt, d_n);
    check("i_miss_cnt_w4", i_miss_cnt_s, sat15(i_n));
    check("d_miss_cnt_w4", d_miss_cnt_s, sat15(d_n));
  endtask

  // Called at a negedge in IDLE with the served side's miss already driven.
  // Returns at the negedge of the IDLE cycle after the fill.
  task automatic serve(input bit side_d, input logic [31:0] a, input int delay,
                       input logic [63:0] data, input bit i_pending);
    logic [31:0] exp_line;
    logic [4:0]  exp_idx;
    logic [23:0] exp_tag;
    exp_line = a & 32'hFFFF_FFF8;
    exp_idx  = 5'((a >> 3) % 32);
    exp_tag  = 24'(a >> 8);
    #1;
    check("stall_on_miss", side_d ? d_stall : i_stall, 1);
    check("idle_no_req", mem_req, 0);
    @(negedge clk);
    if (side_d) d_n++; else i_n++;
    check("req_rise", mem_req, 1);
    check("mem_addr", mem_addr, exp_line);
    check("stall_req", side_d ? d_stall : i_stall, 1);
    if (i_pending) check("i_stall_pending", i_stall, 1);
    for (int k = 0; k < delay; k++) begin
      if (side_d) d_addr = 32'h0000_0FF8; else i_addr = $urandom;
      @(negedge clk);
      check("req_hold", mem_req, 1);
      check("mem_addr_hold", mem_addr, exp_line);
      check("no_early_fill", {i_fill, d_fill}, 0);
      if (i_pending) check("i_stall_pending", i_stall, 1);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = {$urandom, $urandom};
    check("fill_side", {i_fill, d_fill}, side_d ? 2'b01 : 2'b10);
    check("fill_idx", fill_idx, exp_idx);
    check("fill_tag", fill_tag, exp_tag);
    check("fill_data", fill_data, data);
    check("req_drop", mem_req, 0);
    check("stall_fill", side_d ? d_stall : i_stall, 1);
    if (side_d) d_miss = 1'b0; else i_miss = 1'b0;
    @(negedge clk);
    check("fill_one_cycle", {i_fill, d_fill}, 0);
    check_counters();
  endtask

  task automatic idle_probe();
    // d_miss without d_en, plus a stray ack: nothing may happen.
    i_miss = 1'b0; d_en = 1'b0; d_miss = 1'b1; d_addr = $urandom;
    #1;
    check("d_stall_no_en", d_stall, 0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("no_req_no_en", mem_req, 0);
    @(negedge clk);
    check("no_fill_idle_ack", {i_fill, d_fill}, 0);
    check("no_req_no_en2", mem_req, 0);
    check_counters();
    d_miss = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_addr = '0; d_addr = '0; i_miss = 0; d_en = 0; d_miss = 0;
    mem_ack = 0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_fill_data", fill_data, 0);
    check("rst_fills", {i_fill, d_fill}, 0);
    check("rst_fill_idx", fill_idx, 0);
    check("rst_fill_tag", fill_tag, 0);
    check_counters();
    reset = 1'b0;
    @(negedge clk);

    // Single icache miss, ack two cycles after mem_req rises.
    i_addr = 32'h0000_1234; i_miss = 1'b1;
    serve(0, 32'h0000_1234, 2, 64'h0123_4567_89AB_CDEF, 0);
    check("plan_i_cnt", i_miss_cnt, 1);

    // Simultaneous misses: data first, instruction taken right after.
    d_addr = 32'h8000_0040; d_en = 1; d_miss = 1;
    i_addr = 32'h0000_0100; i_miss = 1;
    serve(1, 32'h8000_0040, 2, {$urandom, $urandom}, 1);
    serve(0, 32'h0000_0100, 1, {$urandom, $urandom}, 0);

    idle_probe();

    // Reset while a request is outstanding, then a late ack.
    i_addr = $urandom; i_miss = 1'b1;
    @(negedge clk);
    i_n++;
    check("pre_rst_req", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    i_n = 0; d_n = 0;
    check("rst_async_req", mem_req, 0);
    check("rst_async_fill", {i_fill, d_fill}, 0);
    check_counters();
    i_miss = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_no_fill", {i_fill, d_fill}, 0);
    check("late_ack_no_req", mem_req, 0);
    @(negedge clk);
    check("late_ack_no_fill2", {i_fill, d_fill}, 0);
    check_counters();

    // Twenty icache misses drive the 4-bit counter into saturation.
    for (int n = 0; n < 20; n++) begin
      logic [31:0] a;
      a = $urandom;
      i_addr = a; i_miss = 1'b1; d_en = 1'($urandom); d_miss = 1'b0;
      serve(0, a, int'($urandom_range(0, 1)), {$urandom, $urandom}, 0);
    end
    check("sat_i_cnt_w4", i_miss_cnt_s, 15);

    // Randomized mix of scenarios.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] ia, da;
      int sc;
      ia = $urandom; da = $urandom;
      sc = int'($urandom_range(0, 3));
      case (sc)
        0: begin
          i_addr = ia; i_miss = 1; d_en = 1'($urandom); d_miss = 0;
          serve(0, ia, int'($urandom_range(0, 3)), {$urandom, $urandom}, 0);
        end
        1: begin
          d_addr = da; d_en = 1; d_miss = 1; i_miss = 0;
          serve(1, da, int'($urandom_range(0, 3)), {$urandom, $urandom}, 0);
        end
        2: begin
          d_addr = da; d_en = 1; d_miss = 1; i_addr = ia; i_miss = 1;
          serve(1, da, int'($urandom_range(0, 3)), {$urandom, $urandom}, 1);
          serve(0, ia, int'($urandom_range(0, 3)), {$urandom, $urandom}, 0);
        end
        default: idle_probe();
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
